// File: rtl/serial_mod_checker.sv
// -----------------------------------------------------------------------------
// serial_mod_checker
//
// Serial divisibility checker. A framed bit stream arrives one bit per
// accepted beat. The block tracks the remainder of the framed integer modulo
// DIVISOR. At the end of each frame it reports whether the frame value is
// divisible, and it keeps a saturating count of divisible frames.
//
// Parameters:
//   DIVISOR    modulus N, legal range 2 .. 2^16-1
//   FRAME_LEN  bits per frame, at least 1
//   CNT_W      width of the divisible-frame counter
//   RW         (local) remainder width, $clog2(DIVISOR)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_bit / in_start are sampled this cycle
//   in_bit      serial data bit (MSB-first by default)
//   in_start    qualified by in_valid, marks the first bit of a frame
//   out_rem     running remainder of the current or last frame
//   out_div     out_rem == 0
//   busy        high while accumulating a frame
//   frame_done  one-cycle pulse after the last bit of a frame is accepted
//   frame_div   last completed frame was divisible (held until next frame_done)
//   div_cnt     saturating count of divisible frames
//   proto_err   one-cycle pulse for a non-start beat while idle
//
// Build option:
//   SERIAL_MOD_LSB_FIRST_EN  when defined, bits arrive LSB-first and a
//                            weight register tracks 2^k mod N
// -----------------------------------------------------------------------------
module serial_mod_checker #(
    parameter  int DIVISOR   = 5,
    parameter  int FRAME_LEN = 8,
    parameter  int CNT_W     = 16,
    localparam int RW        = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_start,
    output logic [RW-1:0]    out_rem,
    output logic             out_div,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_div,
    output logic [CNT_W-1:0] div_cnt,
    output logic             proto_err
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [RW:0]   N_EXT    = (RW + 1)'(DIVISOR);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t        state;
    logic [CW-1:0] bitcnt;
    logic [CW-1:0] bitcnt_inc;
    logic          start_beat;
    logic          acc_beat;
    logic          frame_end;
    logic [RW:0]   rem_sum;
    logic [RW-1:0] rem_nxt;

    // A start beat is honoured in either state (it aborts a frame in
    // progress); ordinary data beats only count while accumulating.
    assign start_beat = in_valid && in_start;
    assign acc_beat   = in_valid && !in_start && (state == ACCUM);
    assign bitcnt_inc = bitcnt + CW'(1);

    // With a one-bit frame the start beat is also the last beat.
    assign frame_end  = (start_beat && (FRAME_LEN == 1)) ||
                        (acc_beat && (bitcnt_inc == LAST_CNT));

    assign out_div = (out_rem == '0);
    assign busy    = (state == ACCUM);

`ifdef SERIAL_MOD_LSB_FIRST_EN
    logic [RW-1:0] w;
    logic [RW-1:0] w_base;
    logic [RW:0]   w_dbl;
    logic [RW-1:0] w_nxt;

    // LSB-first: each bit is weighted by 2^k mod N. Both the remainder sum
    // and the doubled weight stay below 2N, so one conditional subtract
    // reduces them exactly. A start beat restarts from weight 1.
    always_comb begin
        w_base  = start_beat ? RW'(1) : w;
        rem_sum = start_beat ? (RW + 1)'(in_bit)
                             : ({1'b0, out_rem} + (in_bit ? {1'b0, w} : '0));
        rem_nxt = (rem_sum >= N_EXT) ? RW'(rem_sum - N_EXT) : RW'(rem_sum);
        w_dbl   = {w_base, 1'b0};
        w_nxt   = (w_dbl >= N_EXT) ? RW'(w_dbl - N_EXT) : RW'(w_dbl);
    end
`else
    // MSB-first: t = 2*rem + bit is below 2N, so one conditional subtract
    // gives t mod N. A start beat treats the previous remainder as zero.
    always_comb begin
        rem_sum = {(start_beat ? {RW{1'b0}} : out_rem), in_bit};
        rem_nxt = (rem_sum >= N_EXT) ? RW'(rem_sum - N_EXT) : RW'(rem_sum);
    end
`endif

    // Frame FSM plus all registered status. The remainder only moves on an
    // accepted beat, so it holds the last frame's value while idle. Frame
    // completion results use the remainder being written on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_rem    <= '0;
            bitcnt     <= '0;
            frame_done <= 1'b0;
            frame_div  <= 1'b0;
            div_cnt    <= '0;
            proto_err  <= 1'b0;
`ifdef SERIAL_MOD_LSB_FIRST_EN
            w          <= RW'(1);
`endif
        end else begin
            frame_done <= frame_end;
            proto_err  <= in_valid && !in_start && (state == IDLE);

            if (start_beat || acc_beat) begin
                out_rem <= rem_nxt;
`ifdef SERIAL_MOD_LSB_FIRST_EN
                w       <= w_nxt;
`endif
            end

            if (frame_end) begin
                frame_div <= (rem_nxt == '0);
                if ((rem_nxt == '0) && (div_cnt != '1)) begin
                    div_cnt <= div_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start_beat) begin
                        if (FRAME_LEN == 1) begin
                            bitcnt <= '0;
                        end else begin
                            bitcnt <= CW'(1);
                            state  <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (start_beat) begin
                        bitcnt <= CW'(1);
                    end else if (acc_beat) begin
                        if (frame_end) begin
                            bitcnt <= '0;
                            state  <= IDLE;
                        end else begin
                            bitcnt <= bitcnt_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
